// File: rtl/unpacker.sv
// -----------------------------------------------------------------------------
// unpacker
//   Converts a packed 24-bit pixel byte stream (four pixels per three 32-bit
//   words, per-pixel byte order g,b,r) into one pixel per output transfer.
//
//   Word layout (byte0..byte3):
//     W0 = g0 b0 r0 g1 | W1 = b1 r1 g2 b2 | W2 = r2 g3 b3 r3
//
// Ports
//   aclk, aresetn      clock, asynchronous active-low reset
//   in_stream_tdata    packed input word, byte0 = bits[7:0]
//   in_stream_tkeep    ignored, every word is taken as full
//   in_stream_tlast    last word of a line
//   in_stream_tuser    first word of a frame
//   in_stream_tvalid   input word valid
//   in_stream_tready   input word accepted when tvalid && tready
//   r, g, b            unpacked pixel colour
//   valid / ready      output pixel handshake
//   sof / eol          pixel is first of frame / last of line
//   pack_err           sticky malformed-stream flag, cleared only by reset
// -----------------------------------------------------------------------------
module unpacker (
   input  logic        aclk,
   input  logic        aresetn,
   input  logic [31:0] in_stream_tdata,
   input  logic [3:0]  in_stream_tkeep,
   input  logic        in_stream_tlast,
   input  logic        in_stream_tuser,
   input  logic        in_stream_tvalid,
   output logic        in_stream_tready,
   output logic [7:0]  r,
   output logic [7:0]  g,
   output logic [7:0]  b,
   output logic        valid,
   input  logic        ready,
   output logic        sof,
   output logic        eol,
   output logic        pack_err
);

   typedef enum logic [1:0] {
      PH0 = 2'd0,
      PH1 = 2'd1,
      PH2 = 2'd2,
      PH3 = 2'd3
   } phase_t;

   phase_t      r_phase, w_phase_nxt;
   logic [23:0] r_carry, w_carry_nxt;   // leftover bytes, first pending byte in [7:0]
   logic        r_last,  w_last_nxt;    // tlast seen on the phase-2 word
   logic [7:0]  r_r, r_g, r_b, w_r_nxt, w_g_nxt, w_b_nxt;
   logic        r_valid, r_sof, r_eol, r_err;
   logic        w_valid_nxt, w_sof_nxt, w_eol_nxt, w_err_nxt;
   logic        w_load_en, w_accept, w_resync;
   logic        w_unused_tkeep;

   assign w_unused_tkeep   = ^in_stream_tkeep;
   assign w_load_en        = !r_valid || ready;
   assign in_stream_tready = aresetn && w_load_en && (r_phase != PH3);
   assign w_accept         = in_stream_tvalid && in_stream_tready;
   // tuser forces a phase-0 decode regardless of the current phase
   assign w_resync         = in_stream_tuser || (r_phase == PH0);

   always_comb begin
      w_phase_nxt = r_phase;
      w_carry_nxt = r_carry;
      w_last_nxt  = r_last;
      w_r_nxt     = r_r;
      w_g_nxt     = r_g;
      w_b_nxt     = r_b;
      w_valid_nxt = r_valid;
      w_sof_nxt   = r_sof;
      w_eol_nxt   = r_eol;
      w_err_nxt   = r_err;

      if (w_load_en) begin
         if (r_phase == PH3) begin
            // fourth pixel comes entirely from the carry, no word consumed
            w_g_nxt     = r_carry[7:0];
            w_b_nxt     = r_carry[15:8];
            w_r_nxt     = r_carry[23:16];
            w_valid_nxt = 1'b1;
            w_sof_nxt   = 1'b0;
            w_eol_nxt   = r_last;
            w_carry_nxt = '0;
            w_last_nxt  = 1'b0;
            w_phase_nxt = PH0;
         end else if (w_accept) begin
            w_valid_nxt = 1'b1;
            w_sof_nxt   = 1'b0;
            w_eol_nxt   = 1'b0;
            if (w_resync) begin
               w_g_nxt     = in_stream_tdata[7:0];
               w_b_nxt     = in_stream_tdata[15:8];
               w_r_nxt     = in_stream_tdata[23:16];
               w_sof_nxt   = in_stream_tuser;
               w_carry_nxt = {16'h0000, in_stream_tdata[31:24]};
               w_phase_nxt = PH1;
               if (r_phase != PH0) begin
                  w_err_nxt = 1'b1;
               end
            end else if (r_phase == PH1) begin
               w_g_nxt     = r_carry[7:0];
               w_b_nxt     = in_stream_tdata[7:0];
               w_r_nxt     = in_stream_tdata[15:8];
               w_carry_nxt = {8'h00, in_stream_tdata[31:16]};
               w_phase_nxt = PH2;
            end else begin
               w_g_nxt     = r_carry[7:0];
               w_b_nxt     = r_carry[15:8];
               w_r_nxt     = in_stream_tdata[7:0];
               w_carry_nxt = in_stream_tdata[31:8];
               w_last_nxt  = in_stream_tlast;
               w_phase_nxt = PH3;
            end
            // tlast anywhere but a completing phase-2 word truncates the group;
            // evaluated after the tuser decode so both rules compose
            if (in_stream_tlast && (w_phase_nxt != PH3)) begin
               w_eol_nxt   = 1'b1;
               w_carry_nxt = '0;
               w_phase_nxt = PH0;
               w_err_nxt   = 1'b1;
            end
         end else begin
            w_valid_nxt = 1'b0;
         end
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_phase <= PH0;
         r_carry <= '0;
         r_last  <= 1'b0;
         r_r     <= '0;
         r_g     <= '0;
         r_b     <= '0;
         r_valid <= 1'b0;
         r_sof   <= 1'b0;
         r_eol   <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_phase <= w_phase_nxt;
         r_carry <= w_carry_nxt;
         r_last  <= w_last_nxt;
         r_r     <= w_r_nxt;
         r_g     <= w_g_nxt;
         r_b     <= w_b_nxt;
         r_valid <= w_valid_nxt;
         r_sof   <= w_sof_nxt;
         r_eol   <= w_eol_nxt;
         r_err   <= w_err_nxt;
      end
   end

   assign r        = r_r;
   assign g        = r_g;
   assign b        = r_b;
   assign valid    = r_valid;
   assign sof      = r_sof;
   assign eol      = r_eol;
   assign pack_err = r_err;

endmodule

// File: tb/tb_unpacker.sv
// -----------------------------------------------------------------------------
// tb_unpacker
//   Scoreboard bench for unpacker. Expected pixels are queued when stimulus
//   is issued; a monitor pops and compares on every output transfer.
// -----------------------------------------------------------------------------
module tb_unpacker;

   logic        aclk = 1'b0;
   logic        aresetn;
   logic [31:0] in_stream_tdata;
   logic [3:0]  in_stream_tkeep;
   logic        in_stream_tlast;
   logic        in_stream_tuser;
   logic        in_stream_tvalid;
   logic        in_stream_tready;
   logic [7:0]  r, g, b;
   logic        valid, ready, sof, eol, pack_err;

   int unsigned checks = 0;
   int unsigned errors = 0;
   int unsigned popped = 0;
   logic        rnd_ready = 1'b0;

   // expected pixel: {g, b, r, sof, eol}
   logic [25:0] exp_q[$];

   unpacker dut (
      .aclk             (aclk),
      .aresetn          (aresetn),
      .in_stream_tdata  (in_stream_tdata),
      .in_stream_tkeep  (in_stream_tkeep),
      .in_stream_tlast  (in_stream_tlast),
      .in_stream_tuser  (in_stream_tuser),
      .in_stream_tvalid (in_stream_tvalid),
      .in_stream_tready (in_stream_tready),
      .r                (r),
      .g                (g),
      .b                (b),
      .valid            (valid),
      .ready            (ready),
      .sof              (sof),
      .eol              (eol),
      .pack_err         (pack_err)
   );

   always #5 aclk = ~aclk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic push_px(input logic [7:0] pg, input logic [7:0] pb, input logic [7:0] pr,
                          input logic psof, input logic peol);
      exp_q.push_back({pg, pb, pr, psof, peol});
   endtask

   // Pixels of one well-formed group: the 12 bytes read as g,b,r triples.
   task automatic push_group(input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2,
                             input logic user, input logic last);
      logic [7:0] bytes[$];
      logic [31:0] w[3];
      w[0] = w0; w[1] = w1; w[2] = w2;
      for (int i = 0; i < 3; i++)
         for (int k = 0; k < 4; k++)
            bytes.push_back(w[i][8*k +: 8]);
      for (int p = 0; p < 4; p++)
         push_px(bytes[3*p], bytes[3*p+1], bytes[3*p+2], user && (p == 0), last && (p == 3));
   endtask

   task automatic send_word(input logic [31:0] d, input logic user, input logic last);
      logic acc;
      bit   done;
      in_stream_tdata  = d;
      in_stream_tuser  = user;
      in_stream_tlast  = last;
      in_stream_tkeep  = 4'($urandom);
      in_stream_tvalid = 1'b1;
      done = 0;
      for (int c = 0; c < 200 && !done; c++) begin
         @(negedge aclk);
         acc = in_stream_tready;
         @(posedge aclk);
         #1;
         if (acc) done = 1;
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL word_accept: word %h not accepted within 200 cycles", d);
      end
   endtask

   task automatic idle();
      in_stream_tvalid = 1'b0;
      in_stream_tuser  = 1'b0;
      in_stream_tlast  = 1'b0;
   endtask

   task automatic drain();
      int unsigned c = 0;
      while (exp_q.size() != 0 && c < 3000) begin
         @(negedge aclk);
         c++;
      end
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain: %0d pixels still expected, got none", exp_q.size());
         exp_q.delete();
      end
      @(posedge aclk);
      #1;
   endtask

   task automatic pulse_reset();
      aresetn = 1'b0;
      #1;
      check("rst_async_outputs", {valid, sof, eol, pack_err, r, g, b}, 32'h0);
      @(negedge aclk);
      check("rst_tready", {31'h0, in_stream_tready}, 32'h0);
      aresetn = 1'b1;
      @(posedge aclk);
      #1;
      check("post_rst_tready", {31'h0, in_stream_tready}, 32'h1);
   endtask

   // Monitor: one comparison per output transfer
   initial begin
      forever begin
         @(negedge aclk);
         if (aresetn && valid && ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL pixel_unexpected: got g=%h b=%h r=%h sof=%b eol=%b, none expected",
                        g, b, r, sof, eol);
            end else begin
               logic [25:0] e;
               e = exp_q.pop_front();
               if ({g, b, r, sof, eol} !== e) begin
                  errors++;
                  $display("FAIL pixel_%0d: got g=%h b=%h r=%h sof=%b eol=%b expected g=%h b=%h r=%h sof=%b eol=%b",
                           popped, g, b, r, sof, eol, e[25:18], e[17:10], e[9:2], e[1], e[0]);
               end
            end
            popped++;
         end
      end
   end

   // Random downstream backpressure
   initial begin
      forever begin
         @(posedge aclk);
         #1;
         if (rnd_ready) ready = ($urandom_range(0, 2) != 0);
      end
   end

   initial begin
      logic [25:0] held;
      bit          seen;
      aresetn = 1'b0;
      ready   = 1'b0;
      in_stream_tdata = '0;
      in_stream_tkeep = '0;
      idle();

      // Reset state
      repeat (3) @(negedge aclk);
      check("reset_outputs", {valid, sof, eol, pack_err, r, g, b}, 32'h0);
      check("reset_tready", {31'h0, in_stream_tready}, 32'h0);
      aresetn = 1'b1;
      @(posedge aclk);
      #1;
      check("release_tready", {31'h0, in_stream_tready}, 32'h1);

      // Nominal group
      ready = 1'b1;
      push_group(32'h44332211, 32'h88776655, 32'hCCBBAA99, 1'b1, 1'b1);
      send_word(32'h44332211, 1'b1, 1'b0);
      check("latency_first_px", {7'h0, valid, g, b, r}, {7'h0, 1'b1, 24'h112233});
      send_word(32'h88776655, 1'b0, 1'b0);
      send_word(32'hCCBBAA99, 1'b0, 1'b1);
      idle();
      check("tready_phase3", {31'h0, in_stream_tready}, 32'h0);
      @(posedge aclk);
      #1;
      check("tready_after_phase3", {31'h0, in_stream_tready}, 32'h1);
      drain();
      check("nominal_pack_err", {31'h0, pack_err}, 32'h0);

      // Backpressure on the first pixel
      ready = 1'b0;
      push_group(32'h44332211, 32'h88776655, 32'hCCBBAA99, 1'b1, 1'b1);
      fork
         begin
            send_word(32'h44332211, 1'b1, 1'b0);
            send_word(32'h88776655, 1'b0, 1'b0);
            send_word(32'hCCBBAA99, 1'b0, 1'b1);
            idle();
         end
         begin
            seen = 0;
            for (int c = 0; c < 50 && !seen; c++) begin
               @(negedge aclk);
               if (valid) seen = 1;
            end
            check("bp_valid_seen", {31'h0, seen}, 32'h1);
            held = {g, b, r, sof, eol};
            check("bp_first_px", {6'h0, held}, {6'h0, 8'h11, 8'h22, 8'h33, 1'b1, 1'b0});
            for (int c = 0; c < 5; c++) begin
               @(negedge aclk);
               check("bp_hold", {6'h0, valid, g, b, r, sof, eol}, {5'h0, 1'b1, held});
               check("bp_tready", {31'h0, in_stream_tready}, 32'h0);
            end
            @(posedge aclk);
            #1;
            ready = 1'b1;
         end
      join
      drain();

      // Early tlast on W1, next word decodes as phase 0
      push_px(8'h11, 8'h22, 8'h33, 1'b1, 1'b0);
      push_px(8'h44, 8'h55, 8'h66, 1'b0, 1'b1);
      send_word(32'h44332211, 1'b1, 1'b0);
      send_word(32'h88776655, 1'b0, 1'b1);
      idle();
      push_group(32'h0C0B0A09, 32'h100F0E0D, 32'h14131211, 1'b0, 1'b0);
      send_word(32'h0C0B0A09, 1'b0, 1'b0);
      send_word(32'h100F0E0D, 1'b0, 1'b0);
      send_word(32'h14131211, 1'b0, 1'b0);
      idle();
      drain();
      check("early_tlast_pack_err", {31'h0, pack_err}, 32'h1);

      // tuser and tlast together in phase 1 -> sof, eol, back to phase 0
      push_px(8'h11, 8'h22, 8'h33, 1'b0, 1'b0);
      push_px(8'h01, 8'h02, 8'h03, 1'b1, 1'b1);
      send_word(32'h44332211, 1'b0, 1'b0);
      send_word(32'h04030201, 1'b1, 1'b1);
      idle();
      push_group(32'h44332211, 32'h88776655, 32'hCCBBAA99, 1'b0, 1'b0);
      send_word(32'h44332211, 1'b0, 1'b0);
      send_word(32'h88776655, 1'b0, 1'b0);
      send_word(32'hCCBBAA99, 1'b0, 1'b0);
      idle();
      drain();
      pulse_reset();
      check("err_cleared_by_reset", {31'h0, pack_err}, 32'h0);

      // Resync: tuser in phase 2
      push_px(8'h11, 8'h22, 8'h33, 1'b1, 1'b0);
      push_px(8'h44, 8'h55, 8'h66, 1'b0, 1'b0);
      push_px(8'h01, 8'h02, 8'h03, 1'b1, 1'b0);
      push_px(8'h04, 8'h05, 8'h06, 1'b0, 1'b0);
      push_px(8'h07, 8'h08, 8'h09, 1'b0, 1'b0);
      push_px(8'h0A, 8'h0B, 8'h0C, 1'b0, 1'b1);
      send_word(32'h44332211, 1'b1, 1'b0);
      send_word(32'h88776655, 1'b0, 1'b0);
      send_word(32'h04030201, 1'b1, 1'b0);
      send_word(32'h08070605, 1'b0, 1'b0);
      send_word(32'h0C0B0A09, 1'b0, 1'b1);
      idle();
      drain();
      check("resync_pack_err", {31'h0, pack_err}, 32'h1);
      pulse_reset();

      // Reset mid-group: carry from W0 is lost
      push_px(8'h11, 8'h22, 8'h33, 1'b1, 1'b0);
      send_word(32'h44332211, 1'b1, 1'b0);
      idle();
      drain();
      pulse_reset();
      push_group(32'h44332211, 32'h88776655, 32'hCCBBAA99, 1'b0, 1'b1);
      send_word(32'h44332211, 1'b0, 1'b0);
      send_word(32'h88776655, 1'b0, 1'b0);
      send_word(32'hCCBBAA99, 1'b0, 1'b1);
      idle();
      drain();
      check("mid_reset_pack_err", {31'h0, pack_err}, 32'h0);

      // Random well-formed stream, 250 groups = 1000 pixels, random stalls
      rnd_ready = 1'b1;
      for (int grp = 0; grp < 250; grp++) begin
         logic [31:0] w0, w1, w2;
         logic        u, l;
         w0 = $urandom;
         w1 = $urandom;
         w2 = $urandom;
         u  = ($urandom_range(0, 7) == 0);
         l  = ($urandom_range(0, 3) == 0);
         push_group(w0, w1, w2, u, l);
         send_word(w0, u, 1'b0);
         if ($urandom_range(0, 2) == 0) begin idle(); repeat ($urandom_range(1, 3)) @(posedge aclk); #1; end
         send_word(w1, 1'b0, 1'b0);
         if ($urandom_range(0, 2) == 0) begin idle(); repeat ($urandom_range(1, 3)) @(posedge aclk); #1; end
         send_word(w2, 1'b0, l);
         idle();
         if ($urandom_range(0, 2) == 0) begin repeat ($urandom_range(1, 3)) @(posedge aclk); #1; end
      end
      @(posedge aclk);
      #1;
      rnd_ready = 1'b0;
      ready     = 1'b1;
      drain();
      repeat (4) @(posedge aclk);
      #1;
      check("random_no_extra_px", {31'h0, valid}, 32'h0);
      check("random_pack_err", {31'h0, pack_err}, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Global watchdog
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/unpacker.md
UNPACKER -- requirements
Module: unpacker

Interface
REQ-001 Parameters: none; the pixel format is fixed at 24-bit, packed four pixels per three 32-bit words.
REQ-002 aclk  input  1  single clock; all state changes on the rising edge.
REQ-003 aresetn  input  1  reset, asynchronous, active-low.
REQ-004 in_stream_tdata  input  32  packed byte stream; byte0 = bits[7:0].
REQ-005 in_stream_tkeep  input  4  ignored; every word is taken as full.
REQ-006 in_stream_tlast  input  1  last word of a line.
REQ-007 in_stream_tuser  input  1  first word of a frame.
REQ-008 in_stream_tvalid  input  1  word valid.
REQ-009 in_stream_tready  output  1  word accepted when tvalid and tready are both high.
REQ-010 r, g, b  output  8 each  unpacked pixel colour.
REQ-011 valid  output  1  pixel valid.
REQ-012 ready  input  1  downstream accepts the pixel when valid and ready are both high.
REQ-013 sof  output  1  pixel is the first of a frame.
REQ-014 eol  output  1  pixel is the last of a line.
REQ-015 pack_err  output  1  sticky flag for a malformed stream.

Function
REQ-016 Per-pixel byte order shall be g, b, r.
REQ-017 Word layout, byte0 to byte3, shall be:
- W0 = g0 b0 r0 g1
- W1 = b1 r1 g2 b2
- W2 = r2 g3 b3 r3
REQ-018 A 2-bit phase register shall count 0..3; the 24-bit carry register shall hold the leftover bytes.
REQ-019 Output register load: the r/g/b/valid/sof/eol register shall load when valid=0 or ready=1 (load_en).
REQ-020 in_stream_tready shall equal load_en AND (phase != 3).
REQ-021 Phase behaviour:
- Phase 0, word accepted: emit {g0,b0,r0}; carry g1; go to phase 1.
- Phase 1, word accepted: emit {carry g1, b1, r1}; carry g2,b2; go to phase 2.
- Phase 2, word accepted: emit {g2, b2, r2}; carry g3,b3,r3; go to phase 3.
- Phase 3: on load_en, emit {g3,b3,r3} from carry with no input consumed; go to phase 0.
REQ-022 On load_en with no word accepted and phase != 3, valid shall be cleared to 0.
REQ-023 Latency: a pixel shall appear on the outputs exactly one cycle after its completing word is accepted.
REQ-024 Sustained throughput with ready held high shall be 4 pixels per 4 cycles, i.e. 3 words accepted every 4 cycles.
REQ-025 sof shall be set on the first pixel emitted from a word with tuser=1, and cleared on every other pixel.
REQ-026 tlast on a phase-2 word shall be stored and emitted as eol=1 on the following phase-3 pixel; the phase-2 pixel shall have eol=0.
REQ-027 tlast on a phase-0 or phase-1 word is malformed and shall:
- emit that word's pixel with eol=1;
- discard the carry;
- return phase to 0;
- set pack_err.
REQ-028 tuser on a word arriving in phase 1 or 2 shall:
- decode the word as a phase-0 word (emit {g0,b0,r0}, sof=1);
- discard the old carry;
- go to phase 1;
- set pack_err.
REQ-029 When tuser and a malformed tlast arrive on the same word, the tuser rule shall apply first, then the tlast rule.
- Result: phase 0, sof=1, eol=1, pack_err=1.
REQ-030 pack_err shall clear only on reset.
REQ-031 Output hold: while valid=1 and ready=0, r/g/b/sof/eol shall hold stable and in_stream_tready shall be 0.

Reset
REQ-032 While aresetn=0, and immediately on its assertion, the following shall be 0: phase, carry, valid, sof, eol, pack_err, r, g, b.
REQ-033 in_stream_tready shall be 0 while aresetn=0.
REQ-034 After release, in_stream_tready shall be 1 from the first clock edge; a partial group in flight at reset shall be lost with no partial pixel emitted.

Verification
REQ-035 Nominal group: W0=0x44332211 (tuser=1), W1=0x88776655, W2=0xCCBBAA99 (tlast=1), ready=1 -> pixels out in order:
- (g,b,r)=(11,22,33) with sof=1
- (44,55,66)
- (77,88,99)
- (AA,BB,CC) with eol=1
- pack_err=0; tready low only in the phase-3 cycle.
REQ-036 Backpressure: same words, ready=0 for 5 cycles after the first pixel -> first pixel held stable, tready=0, no word lost; then the remaining three pixels emitted in order.
REQ-037 Early tlast: tlast=1 on W1=0x88776655 after W0=0x44332211 -> second pixel (44,55,66) with eol=1; pack_err=1; next word decoded as phase 0.
REQ-038 Resync: tuser=1 on a word 0x04030201 in phase 2 -> pixel (01,02,03) with sof=1; pack_err=1; phase=1.
REQ-039 Reset mid-group: aresetn pulsed low after W0 is accepted -> valid=0 within the reset; next word 0x44332211 yields (11,22,33).
REQ-040 Random stall: 1000 random pixels with random tvalid/ready gaps -> output equals the reference byte-order model; no duplicated or dropped pixels.
